// File: rtl/pcie_rd_dma_sched.sv
// PCIe read-DMA request scheduler: splits a host read into chunk-sized requests issued
// round-robin over NUM_BUF tags/buffers and steers completion beats to the owning buffer.
module pcie_rd_dma_sched #(
    parameter int NUM_BUF     = 4,
    parameter int CHUNK_BYTES = 4096,
    parameter int TAG_BASE    = 0
) (
    input  logic               pcie_clk_i,
    input  logic               rst_n,
    input  logic               ctrl_en_i,
    input  logic [31:0]        dma_src_addr_i,
    input  logic [31:0]        dma_len_i,
    output logic               dma_done_o,
    input  logic               dma_done_ack_i,
    output logic               dma_busy_o,
    output logic               dma_err_o,
    output logic               dma_rd_req_o,
    input  logic               dma_req_ack_i,
    output logic [11:0]        dma_rd_req_len_o,
    output logic [31:0]        dma_rd_req_addr_o,
    output logic [7:0]         dma_rd_tag_o,
    input  logic [7:0]         dma_tag_i,
    input  logic               dma_data_valid_i,
    output logic [NUM_BUF-1:0] buf_wr_en_o,
    input  logic [NUM_BUF-1:0] buf_drained_i
);

    localparam int PW = $clog2(NUM_BUF);
    localparam int CW = $clog2(CHUNK_BYTES / 8) + 1;
    localparam int LW = $clog2(CHUNK_BYTES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DATA,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [31:0]     rem_bytes;
    logic [31:0]     addr;
    logic [28:0]     total_exp;
    logic [28:0]     total_rcv;
    logic [LW-1:0]   cur_len;
    logic [CW-1:0]   expt_cnt [NUM_BUF];
    logic [CW-1:0]   rcv_cnt  [NUM_BUF];
    logic [NUM_BUF-1:0] buf_free;
    logic [LW-1:0]   chunk_len;
    logic [31:0]     rem_after;
    logic [8:0]      tag_off;
    logic [PW-1:0]   beat_idx;
    logic            tag_in_range;
    logic            beat_hit;
    logic            beat_stray;
    logic            issue_fire;
    logic            ack_fire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(NUM_BUF - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_BUF; k++) begin
            buf_free[k] = (rcv_cnt[k] == expt_cnt[k]) && buf_drained_i[k];
        end
    end

    always_comb begin
        if (rem_bytes >= 32'(CHUNK_BYTES)) begin
            chunk_len = LW'(CHUNK_BYTES);
        end else begin
            chunk_len = rem_bytes[LW-1:0];
        end
    end

    assign rem_after = rem_bytes - 32'(cur_len);

    // Borrow out of bit 8 means the tag lies below TAG_BASE.
    assign tag_off      = {1'b0, dma_tag_i} - 9'(TAG_BASE);
    assign beat_idx     = tag_off[PW-1:0];
    assign tag_in_range = !tag_off[8] && (tag_off[7:0] < 8'(NUM_BUF));
    assign beat_hit     = dma_data_valid_i && tag_in_range &&
                          (rcv_cnt[beat_idx] < expt_cnt[beat_idx]);
    assign beat_stray   = dma_data_valid_i && !beat_hit;

    assign dma_done_o = (state == S_DONE);
    assign dma_busy_o = (state != S_IDLE);

    always_ff @(posedge pcie_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        issue_fire = 1'b0;
        ack_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (ctrl_en_i) begin
                    state_nxt = (dma_len_i == 32'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (buf_free[ptr]) begin
                    issue_fire = 1'b1;
                    state_nxt  = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (dma_req_ack_i) begin
                    ack_fire  = 1'b1;
                    state_nxt = (rem_after != 32'd0) ? S_ISSUE : S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (total_rcv >= total_exp) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!ctrl_en_i && dma_done_ack_i) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (&buf_drained_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request side: transfer bookkeeping and the held request outputs.
    always_ff @(posedge pcie_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rem_bytes         <= '0;
            addr              <= '0;
            total_exp         <= '0;
            ptr               <= '0;
            cur_len           <= '0;
            dma_rd_req_o      <= 1'b0;
            dma_rd_req_addr_o <= '0;
            dma_rd_req_len_o  <= '0;
            dma_rd_tag_o      <= '0;
            dma_err_o         <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                rem_bytes <= dma_len_i;
                addr      <= dma_src_addr_i;
                total_exp <= dma_len_i[31:3];
                ptr       <= '0;
            end
            if (issue_fire) begin
                dma_rd_req_o      <= 1'b1;
                dma_rd_req_addr_o <= addr;
                dma_rd_req_len_o  <= 12'(chunk_len);
                dma_rd_tag_o      <= 8'(TAG_BASE) + 8'(ptr);
                cur_len           <= chunk_len;
            end
            if (ack_fire) begin
                dma_rd_req_o <= 1'b0;
                rem_bytes    <= rem_after;
                addr         <= addr + 32'(cur_len);
                ptr          <= ptr_inc(ptr);
            end
            if (state != S_IDLE && state_nxt == S_IDLE) begin
                dma_err_o <= 1'b0;
            end else if (beat_stray) begin
                dma_err_o <= 1'b1;
            end
        end
    end

    // Completion side: per-buffer beat counters and registered write enables.
    always_ff @(posedge pcie_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            buf_wr_en_o <= '0;
            total_rcv   <= '0;
            for (int k = 0; k < NUM_BUF; k++) begin
                expt_cnt[k] <= '0;
                rcv_cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_BUF; k++) begin
                buf_wr_en_o[k] <= beat_hit && (beat_idx == PW'(k));
                if (beat_hit && (beat_idx == PW'(k))) begin
                    rcv_cnt[k] <= rcv_cnt[k] + 1'b1;
                end
            end
            if (state == S_IDLE) begin
                total_rcv <= '0;
            end else if (beat_hit) begin
                total_rcv <= total_rcv + 1'b1;
            end
            // A reissued buffer is free, so no beat can hit it in the same cycle.
            if (issue_fire) begin
                expt_cnt[ptr] <= chunk_len[LW-1:3];
                rcv_cnt[ptr]  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pcie_rd_dma_sched.sv
// Scoreboard bench for pcie_rd_dma_sched: expected requests and buffer writes are queued
// by the stimulus side and popped by monitors as the DUT presents them.
module tb_pcie_rd_dma_sched;

    localparam int NB = 4;

    typedef struct {
        logic [31:0] addr;
        logic [11:0] len;
        logic [7:0]  tag;
    } req_t;

    typedef struct {
        logic [7:0] tag;
        int         n;
        bit         stray;
    } job_t;

    typedef struct {
        int          cyc;
        logic [NB-1:0] mask;
    } wr_t;

    logic          pcie_clk_i = 1'b0;
    logic          rst_n = 1'b0;
    logic          ctrl_en_i = 1'b0;
    logic [31:0]   dma_src_addr_i = '0;
    logic [31:0]   dma_len_i = '0;
    logic          dma_done_o;
    logic          dma_done_ack_i = 1'b0;
    logic          dma_busy_o;
    logic          dma_err_o;
    logic          dma_rd_req_o;
    logic          dma_req_ack_i;
    logic [11:0]   dma_rd_req_len_o;
    logic [31:0]   dma_rd_req_addr_o;
    logic [7:0]    dma_rd_tag_o;
    logic [7:0]    dma_tag_i;
    logic          dma_data_valid_i;
    logic [NB-1:0] buf_wr_en_o;
    logic [NB-1:0] buf_drained_i = '1;

    req_t exp_req_q[$];
    job_t job_q[$];
    wr_t  wr_q[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int req_cnt = 0;
    int good_beats = 0;
    bit auto_ack = 1'b1;

    pcie_rd_dma_sched #(
        .NUM_BUF    (NB),
        .CHUNK_BYTES(4096),
        .TAG_BASE   (0)
    ) dut (
        .pcie_clk_i       (pcie_clk_i),
        .rst_n            (rst_n),
        .ctrl_en_i        (ctrl_en_i),
        .dma_src_addr_i   (dma_src_addr_i),
        .dma_len_i        (dma_len_i),
        .dma_done_o       (dma_done_o),
        .dma_done_ack_i   (dma_done_ack_i),
        .dma_busy_o       (dma_busy_o),
        .dma_err_o        (dma_err_o),
        .dma_rd_req_o     (dma_rd_req_o),
        .dma_req_ack_i    (dma_req_ack_i),
        .dma_rd_req_len_o (dma_rd_req_len_o),
        .dma_rd_req_addr_o(dma_rd_req_addr_o),
        .dma_rd_tag_o     (dma_rd_tag_o),
        .dma_tag_i        (dma_tag_i),
        .dma_data_valid_i (dma_data_valid_i),
        .buf_wr_en_o      (buf_wr_en_o),
        .buf_drained_i    (buf_drained_i)
    );

    always #5 pcie_clk_i = ~pcie_clk_i;
    always @(posedge pcie_clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Tx engine: acks each request and hands the matching completion to the Rx feeder.
    initial begin
        req_t r;
        job_t j;
        dma_req_ack_i = 1'b0;
        forever begin
            @(posedge pcie_clk_i); #1;
            if (auto_ack && rst_n && dma_rd_req_o && !dma_req_ack_i) begin
                req_cnt++;
                if (exp_req_q.size() == 0) begin
                    chk("req_unexpected", 32'(dma_rd_req_o), 32'd0);
                end else begin
                    r = exp_req_q.pop_front();
                    chk("req_addr", dma_rd_req_addr_o, r.addr);
                    chk("req_len", 32'(dma_rd_req_len_o), 32'(r.len));
                    chk("req_tag", 32'(dma_rd_tag_o), 32'(r.tag));
                    j.tag   = r.tag;
                    j.n     = (r.len == 12'd0) ? 512 : int'(r.len) / 8;
                    j.stray = 1'b0;
                    job_q.push_back(j);
                end
                dma_req_ack_i = 1'b1;
            end else begin
                dma_req_ack_i = 1'b0;
            end
        end
    end

    // Rx engine: one beat per cycle; each good beat predicts its write enable one cycle later.
    initial begin
        job_t j;
        wr_t  w;
        int   cur_n;
        logic [7:0] cur_tag;
        bit   cur_stray;
        cur_n = 0;
        cur_tag = '0;
        cur_stray = 1'b0;
        dma_data_valid_i = 1'b0;
        dma_tag_i = '0;
        forever begin
            @(posedge pcie_clk_i); #1;
            dma_data_valid_i = 1'b0;
            if (cur_n == 0 && job_q.size() > 0) begin
                j = job_q.pop_front();
                cur_n = j.n;
                cur_tag = j.tag;
                cur_stray = j.stray;
            end
            if (cur_n > 0) begin
                dma_data_valid_i = 1'b1;
                dma_tag_i = cur_tag;
                cur_n--;
                if (!cur_stray) begin
                    good_beats++;
                    w.cyc  = cyc + 1;
                    w.mask = NB'(1) << cur_tag[1:0];
                    wr_q.push_back(w);
                end
            end
        end
    end

    // Buffer write monitor.
    initial begin
        wr_t w;
        forever begin
            @(posedge pcie_clk_i); #1;
            if (buf_wr_en_o != '0) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 32'(buf_wr_en_o), 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_mask", 32'(buf_wr_en_o), 32'(w.mask));
                    chk("wr_latency", cyc, w.cyc);
                end
            end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
                w = wr_q.pop_front();
                chk("wr_missing", 32'(buf_wr_en_o), 32'(w.mask));
            end
        end
    end

    task automatic push_req(input logic [31:0] a, input logic [11:0] l, input logic [7:0] t);
        req_t r;
        r.addr = a;
        r.len  = l;
        r.tag  = t;
        exp_req_q.push_back(r);
    endtask

    task automatic start_xfer(input logic [31:0] a, input logic [31:0] l);
        good_beats = 0;
        dma_src_addr_i = a;
        dma_len_i = l;
        ctrl_en_i = 1'b1;
        @(posedge pcie_clk_i); #1;
        ctrl_en_i = 1'b0;
    endtask

    task automatic finish_xfer(input string nm, input int beats, input logic err_exp);
        int k;
        k = 0;
        while (!dma_done_o && k < 6000) begin
            @(posedge pcie_clk_i); #1;
            k++;
        end
        chk({nm, "_done"}, 32'(dma_done_o), 32'd1);
        chk({nm, "_beats"}, good_beats, beats);
        repeat (3) @(posedge pcie_clk_i);
        #1;
        chk({nm, "_done_hold"}, 32'(dma_done_o), 32'd1);
        chk({nm, "_err"}, 32'(dma_err_o), 32'(err_exp));
        chk({nm, "_reqs_left"}, exp_req_q.size(), 0);
        ctrl_en_i = 1'b0;
        dma_done_ack_i = 1'b1;
        @(posedge pcie_clk_i); #1;
        dma_done_ack_i = 1'b0;
        chk({nm, "_done_drop"}, 32'(dma_done_o), 32'd0);
        k = 0;
        while (dma_busy_o && k < 50) begin
            @(posedge pcie_clk_i); #1;
            k++;
        end
        chk({nm, "_idle"}, 32'(dma_busy_o), 32'd0);
        chk({nm, "_err_clr"}, 32'(dma_err_o), 32'd0);
    endtask

    initial begin
        job_t j;
        int base;
        int k;
        #12;
        chk("rst_req", 32'(dma_rd_req_o), 32'd0);
        chk("rst_done", 32'(dma_done_o), 32'd0);
        chk("rst_busy", 32'(dma_busy_o), 32'd0);
        chk("rst_err", 32'(dma_err_o), 32'd0);
        chk("rst_wr", 32'(buf_wr_en_o), 32'd0);
        chk("rst_tag", 32'(dma_rd_tag_o), 32'd0);
        @(posedge pcie_clk_i); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge pcie_clk_i);
        #1;

        // Four full chunks, tags 0..3.
        push_req(32'h1000_0000, 12'd0, 8'd0);
        push_req(32'h1000_1000, 12'd0, 8'd1);
        push_req(32'h1000_2000, 12'd0, 8'd2);
        push_req(32'h1000_3000, 12'd0, 8'd3);
        start_xfer(32'h1000_0000, 32'd16384);
        finish_xfer("t1", 2048, 1'b0);

        // Full chunk followed by an 8-byte tail.
        push_req(32'h4000_0000, 12'd0, 8'd0);
        push_req(32'h4000_1000, 12'd8, 8'd1);
        start_xfer(32'h4000_0000, 32'd4104);
        finish_xfer("t2", 513, 1'b0);

        // Buffer 0 not drained: fifth request must wait for it, in order.
        push_req(32'h2000_0000, 12'd0, 8'd0);
        push_req(32'h2000_1000, 12'd0, 8'd1);
        push_req(32'h2000_2000, 12'd0, 8'd2);
        push_req(32'h2000_3000, 12'd0, 8'd3);
        push_req(32'h2000_4000, 12'd0, 8'd0);
        base = req_cnt;
        start_xfer(32'h2000_0000, 32'd20480);
        k = 0;
        while (req_cnt == base && k < 100) begin
            @(posedge pcie_clk_i); #1;
            k++;
        end
        buf_drained_i[0] = 1'b0;
        k = 0;
        while (good_beats < 2048 && k < 5000) begin
            @(posedge pcie_clk_i); #1;
            k++;
        end
        repeat (10) @(posedge pcie_clk_i);
        #1;
        chk("t3_stall_reqs", req_cnt - base, 4);
        chk("t3_stall_req", 32'(dma_rd_req_o), 32'd0);
        chk("t3_stall_busy", 32'(dma_busy_o), 32'd1);
        buf_drained_i[0] = 1'b1;
        @(posedge pcie_clk_i); #1;
        chk("t3_release_req", 32'(dma_rd_req_o), 32'd1);
        finish_xfer("t3", 2560, 1'b0);

        // Stray tag and an over-run beat: dropped, error flagged, done still reached.
        push_req(32'h5000_0000, 12'd64, 8'd0);
        base = req_cnt;
        start_xfer(32'h5000_0000, 32'd64);
        k = 0;
        while (req_cnt == base && k < 100) begin
            @(posedge pcie_clk_i); #1;
            k++;
        end
        j.tag = 8'd7; j.n = 1; j.stray = 1'b1;
        job_q.push_back(j);
        j.tag = 8'd0; j.n = 1; j.stray = 1'b1;
        job_q.push_back(j);
        finish_xfer("t4", 8, 1'b1);

        // Zero length: straight to DONE, ack held off while enable is high.
        base = req_cnt;
        dma_src_addr_i = 32'h6000_0000;
        dma_len_i = 32'd0;
        ctrl_en_i = 1'b1;
        @(posedge pcie_clk_i); #1;
        chk("t5_done", 32'(dma_done_o), 32'd1);
        chk("t5_busy", 32'(dma_busy_o), 32'd1);
        chk("t5_no_req", 32'(dma_rd_req_o), 32'd0);
        dma_done_ack_i = 1'b1;
        @(posedge pcie_clk_i); #1;
        chk("t5_ack_en_high", 32'(dma_done_o), 32'd1);
        ctrl_en_i = 1'b0;
        @(posedge pcie_clk_i); #1;
        dma_done_ack_i = 1'b0;
        chk("t5_done_drop", 32'(dma_done_o), 32'd0);
        @(posedge pcie_clk_i); #1;
        chk("t5_idle", 32'(dma_busy_o), 32'd0);
        chk("t5_req_count", req_cnt - base, 0);

        // Asynchronous reset while waiting for the request ack.
        auto_ack = 1'b0;
        start_xfer(32'h3000_0000, 32'd64);
        k = 0;
        while (!dma_rd_req_o && k < 20) begin
            @(posedge pcie_clk_i); #1;
            k++;
        end
        chk("t6_req", 32'(dma_rd_req_o), 32'd1);
        chk("t6_req_addr", dma_rd_req_addr_o, 32'h3000_0000);
        chk("t6_req_len", 32'(dma_rd_req_len_o), 32'd64);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", 32'(dma_rd_req_o), 32'd0);
        chk("t6_rst_addr", dma_rd_req_addr_o, 32'd0);
        chk("t6_rst_len", 32'(dma_rd_req_len_o), 32'd0);
        chk("t6_rst_busy", 32'(dma_busy_o), 32'd0);
        @(posedge pcie_clk_i); #1;
        rst_n = 1'b1;
        auto_ack = 1'b1;
        @(posedge pcie_clk_i); #1;
        chk("t6_idle_after_rst", 32'(dma_busy_o), 32'd0);
        push_req(32'h3000_0100, 12'd8, 8'd0);
        start_xfer(32'h3000_0100, 32'd8);
        finish_xfer("t6", 1, 1'b0);

        repeat (5) @(posedge pcie_clk_i);
        #1;
        chk("end_jobs_left", job_q.size(), 0);
        chk("end_wr_left", wr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d miscompares so far", n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pcie_rd_dma_sched.md
Name: pcie_rd_dma_sched

Overview:
- Parametrised PCIe read-DMA request scheduler; the multi-buffer successor to the two-buffer PCIe-to-DDR DMA controller.
- Splits a host read of `dma_len_i` bytes at `dma_src_addr_i` into chunks of CHUNK_BYTES and issues them round-robin across NUM_BUF tags/buffers.
- A buffer is reused only after its previous completion has fully arrived and the downstream DDR side reports it drained.
- Sits between the register set, the Tx engine (requests) and the Rx engine (completion beats); it steers each beat to the owning buffer's write enable.

Parameters:
- NUM_BUF, 4, number of receive buffers/tags; 2..16.
- CHUNK_BYTES, 4096, maximum bytes per read request; power of 2, 64..4096.
- TAG_BASE, 0, tag of buffer 0; buffer k uses tag TAG_BASE+k; TAG_BASE+NUM_BUF-1 must be at most 255.

Ports:
- pcie_clk_i  in  1  sole clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ctrl_en_i  in  1  start/enable from register set (level).
- dma_src_addr_i  in  32  host byte address, 8-byte aligned.
- dma_len_i  in  32  transfer length in bytes, multiple of 8.
- dma_done_o  out  1  transfer complete.
- dma_done_ack_i  in  1  done acknowledge.
- dma_busy_o  out  1  high when not in IDLE.
- dma_err_o  out  1  sticky: beat received for a stray tag or an over-run.
- dma_rd_req_o  out  1  read request to Tx engine.
- dma_req_ack_i  in  1  Tx engine accepted request.
- dma_rd_req_len_o  out  12  request length in bytes; 0 encodes 4096.
- dma_rd_req_addr_o  out  32  request address.
- dma_rd_tag_o  out  8  request tag.
- dma_tag_i  in  8  completion tag from Rx engine.
- dma_data_valid_i  in  1  one 64-bit completion beat valid.
- buf_wr_en_o  out  NUM_BUF  registered one-hot write enable to the buffers.
- buf_drained_i  in  NUM_BUF  buffer k is empty downstream (synchronous to pcie_clk_i).

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, round-robin pointer 0, all counters 0, dma_err_o 0.
- Per buffer k: expt_cnt[k] and rcv_cnt[k], each clog2(CHUNK_BYTES/8)+1 bits wide, counted in 8-byte beats.
- Buffer k is free when rcv_cnt[k]==expt_cnt[k] and buf_drained_i[k]==1.
- Global counters:
  - rem_bytes (32 bit).
  - total_exp, total_rcv (29 bit, beats).
- Beat steering: if dma_data_valid_i, dma_tag_i is in [TAG_BASE, TAG_BASE+NUM_BUF), and rcv_cnt<expt_cnt for that buffer:
  - the buffer's buf_wr_en_o bit is 1 on the next cycle;
  - rcv_cnt and total_rcv increment.
- Any other valid beat is dropped, sets dma_err_o, and does not count.
- IDLE: latch rem_bytes=dma_len_i, addr=dma_src_addr_i, total_exp=dma_len_i[31:3], total_rcv=0, ptr=0. dma_err_o clears on entering IDLE.
  - If ctrl_en_i and dma_len_i==0: go to DONE.
  - Else if ctrl_en_i: go to ISSUE.
- ISSUE: wait until buffer[ptr] is free; then:
  - len = min(rem_bytes, CHUNK_BYTES);
  - assert dma_rd_req_o, drive addr, tag=TAG_BASE+ptr, dma_rd_req_len_o=len[11:0];
  - set expt_cnt[ptr]=len/8 and rcv_cnt[ptr]=0 in the same cycle;
  - go to WAIT_ACK.
- Buffers other than ptr are never waited on; strictly in-order round-robin.
- WAIT_ACK: hold all request outputs stable until dma_req_ack_i. On ack:
  - drop dma_rd_req_o;
  - rem_bytes -= len, addr += len;
  - ptr = (ptr+1) mod NUM_BUF;
  - go to ISSUE if rem_bytes remains nonzero, else to WAIT_DATA.
- A request lasts at least one cycle; an ack in the same cycle as the request rises counts only from WAIT_ACK.
- WAIT_DATA: when total_rcv>=total_exp, go to DONE.
- DONE: dma_done_o=1. When ~ctrl_en_i & dma_done_ack_i: drop dma_done_o and go to DRAIN.
- DRAIN: when all buf_drained_i bits are 1, go to IDLE.
- ctrl_en_i falling mid-transfer is ignored; the transfer completes.
- An ack while ctrl_en_i is still high holds DONE.
- A beat arriving in the same cycle as a reissue to the same buffer cannot occur, because the buffer was not free; a stray beat then is an error.
- Final partial chunk: expt_cnt = len/8 (e.g. 24 bytes gives 3).
- Latency: completion beat to buf_wr_en_o is 1 cycle. Free buffer to dma_rd_req_o is 1 cycle.

Test Plan:
1. NUM_BUF=4, len=16384, addr=0x1000_0000, all completions returned promptly: 4 requests, tags 0..3, addrs +0x1000, req_len=0; dma_done_o after 2048 beats; dma_err_o=0.
2. len=4104, NUM_BUF=2: request 1 len 0 (4096) tag 0; request 2 len 8 tag 1; done after 513 beats; each buf_wr_en_o bit follows its beat by 1 cycle.
3. len=20480, NUM_BUF=4, buf_drained_i[0] held low after the first fill: the fifth request (tag 0) is stalled and tags 1..3 are not reissued out of order; releasing drained issues it within 1 cycle.
4. Beat with tag 7 (NUM_BUF=4), or an extra beat beyond expt_cnt: nothing is written, dma_err_o=1, done is still reached on valid counts; dma_err_o clears on return to IDLE.
5. len=0 with ctrl_en_i=1: no request issued; dma_done_o=1 next cycle; ack with ctrl_en_i=0 returns the block to IDLE.
6. rst_n pulsed low in WAIT_ACK: outputs 0 immediately (asynchronous); after release the block is in IDLE and a new 8-byte transfer completes normally.
